bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_converter_if.sv | 27 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_converter.sv | 157 +++++++++++++++
 tb/tb_bcd_converter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the
// binary-to-BCD converter.
package bcd_pkg;

  localparam int DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of decimal digits needed to print 2^n-1 (n up to 32).
  function automatic int dec_digits(input int n);
    longint unsigned v;
    int d;
    v = (64'd1 << n) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        d++;
        v = v / 64'd10;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Request/result bundle of the converter: start/binary in, status and
// BCD result out.
interface bcd_converter_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, binary,
    input  busy, done, bcd, neg, ovf, blank
  );

  modport slave (
    input  start, binary,
    output busy, done, bcd, neg, ovf, blank
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following shift carries correctly into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle,
// optional two's-complement input, saturation and leading-zero flags.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 14,
  parameter int DIGITS    = 4,
  parameter int SIGNED_IN = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_converter_if.slave bus
);

  localparam int INT_D = dec_digits(BIN_W);
  localparam int MAX_D = (INT_D > DIGITS) ? INT_D : DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                   state_r, state_s;
  logic                     accept_s, last_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [BIN_W-1:0]         bin_r, mag_s;
  logic                     sign_r, sign_s;
  logic [DIG_W*INT_D-1:0]   dig_r, adj_s, dig_nxt_s;
  logic [DIG_W*MAX_D-1:0]   pad_s;
  logic [DIG_W*DIGITS-1:0]  bcd_s, bcd_r;
  logic [DIGITS-1:0]        blank_s, blank_r;
  logic                     ovf_s, ovf_r, neg_r, busy_r, done_r, zero_run_s;

  for (genvar g = 0; g < INT_D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (dig_r[DIG_W*g +: DIG_W]),
      .adjusted (adj_s[DIG_W*g +: DIG_W])
    );
  end

  assign dig_nxt_s = {adj_s[DIG_W*INT_D-2:0], bin_r[BIN_W-1]};
  assign last_s    = (state_r == CONV) && (cnt_r == CNT_W'(BIN_W - 1));

  // Magnitude and sign of the incoming operand.
  always_comb begin
    mag_s  = bus.binary;
    sign_s = 1'b0;
    if ((SIGNED_IN != 0) && bus.binary[BIN_W-1]) begin
      mag_s  = ~bus.binary + BIN_W'(1);
      sign_s = 1'b1;
    end else begin
      mag_s  = bus.binary;
      sign_s = 1'b0;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s  = CONV;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CONV;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_s  = CONV;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Result formatting from the value the final step will produce.
  always_comb begin
    pad_s                    = '0;
    pad_s[DIG_W*INT_D-1:0]   = dig_nxt_s;
    // The top digit cannot carry out for this INT_D; kept as a guard.
    ovf_s = adj_s[DIG_W*INT_D-1];
    for (int i = DIGITS; i < MAX_D; i++) begin
      ovf_s = ovf_s | (pad_s[DIG_W*i +: DIG_W] != 4'd0);
    end
    bcd_s      = pad_s[DIG_W*DIGITS-1:0];
    blank_s    = '0;
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (pad_s[DIG_W*i +: DIG_W] == 4'd0);
      blank_s[i] = zero_run_s & (i > 0);
    end
    if (ovf_s) begin
      bcd_s   = {DIGITS{4'd9}};
      blank_s = '0;
    end else begin
      bcd_s   = pad_s[DIG_W*DIGITS-1:0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bin_r   <= '0;
      sign_r  <= 1'b0;
      dig_r   <= '0;
      bcd_r   <= '0;
      blank_r <= '0;
      ovf_r   <= 1'b0;
      neg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == CONV);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        bin_r  <= mag_s;
        sign_r <= sign_s;
        dig_r  <= '0;
        cnt_r  <= '0;
      end else if (state_r == CONV) begin
        bin_r  <= {bin_r[BIN_W-2:0], 1'b0};
        dig_r  <= dig_nxt_s;
        cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r  <= cnt_r;
      end
      if (last_s) begin
        bcd_r   <= bcd_s;
        blank_r <= blank_s;
        ovf_r   <= ovf_s;
        neg_r   <= sign_r;
      end else begin
        bcd_r   <= bcd_r;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.bcd   = bcd_r;
  assign bus.neg   = neg_r;
  assign bus.ovf   = ovf_r;
  assign bus.blank = blank_r;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: default unsigned 14-bit/4-digit build
// and a signed 8-bit/3-digit build sharing one clock and reset.
module tb_bcd_converter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   dones;

  always #5 clk = ~clk;

  bcd_converter_if #(.BIN_W(14), .DIGITS(4)) ifa ();
  bcd_converter_if #(.BIN_W(8),  .DIGITS(3)) ifb ();

  bcd_converter #(.BIN_W(14), .DIGITS(4), .SIGNED_IN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  bcd_converter #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic conv_a(input logic [13:0] v, output int n);
    @(negedge clk);
    ifa.start  = 1'b1;
    ifa.binary = v;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    n = 0;
    while (ifa.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic conv_b(input logic [7:0] v, output int n);
    @(negedge clk);
    ifb.start  = 1'b1;
    ifb.binary = v;
    @(posedge clk);
    #1;
    ifb.start = 1'b0;
    n = 0;
    while (ifb.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic res_a(input string tag, input logic [15:0] b, input logic o, input logic [3:0] bl);
    check({tag, "_bcd"},   40'(ifa.bcd),   40'(b));
    check({tag, "_ovf"},   40'(ifa.ovf),   40'(o));
    check({tag, "_blank"}, 40'(ifa.blank), 40'(bl));
  endtask

  initial begin
    ifa.start = 1'b0; ifa.binary = '0;
    ifb.start = 1'b0; ifb.binary = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  40'(ifa.busy),  40'd0);
    check("rst_done",  40'(ifa.done),  40'd0);
    check("rst_bcd",   40'(ifa.bcd),   40'd0);
    check("rst_blank", 40'(ifa.blank), 40'd0);
    check("rst_ovf",   40'(ifa.ovf),   40'd0);
    check("rst_neg_b", 40'(ifb.neg),   40'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv_a(14'd2456, lat);
    check("lat_2456", 40'(lat), 40'd14);
    check("busy_at_done", 40'(ifa.busy), 40'd0);
    res_a("v2456", 16'h2456, 1'b0, 4'b0000);
    conv_a(14'd10000, lat);
    check("lat_10000", 40'(lat), 40'd14);
    res_a("v10000", 16'h9999, 1'b1, 4'b0000);
    conv_a(14'd16383, lat);
    res_a("v16383", 16'h9999, 1'b1, 4'b0000);
    conv_a(14'd0, lat);
    res_a("v0", 16'h0000, 1'b0, 4'b1110);
    conv_a(14'd7, lat);
    res_a("v7", 16'h0007, 1'b0, 4'b1110);
    conv_a(14'd9999, lat);
    res_a("v9999", 16'h9999, 1'b0, 4'b0000);
    conv_a(14'd40, lat);
    res_a("v40", 16'h0040, 1'b0, 4'b1100);

    // Result must hold while binary wiggles without a start.
    @(negedge clk);
    ifa.binary = 14'd1234;
    repeat (5) @(posedge clk);
    #1;
    check("hold_bcd",  40'(ifa.bcd),  40'h0040);
    check("hold_done", 40'(ifa.done), 40'd0);

    conv_b(8'h80, lat);
    check("b_lat",    40'(lat),     40'd8);
    check("b128_neg", 40'(ifb.neg), 40'd1);
    check("b128_bcd", 40'(ifb.bcd), 40'h128);
    check("b128_ovf", 40'(ifb.ovf), 40'd0);
    conv_b(8'd127, lat);
    check("b127_neg", 40'(ifb.neg), 40'd0);
    check("b127_bcd", 40'(ifb.bcd), 40'h127);
    conv_b(8'hFB, lat);
    check("bm5_neg",   40'(ifb.neg),   40'd1);
    check("bm5_bcd",   40'(ifb.bcd),   40'h005);
    check("bm5_blank", 40'(ifb.blank), 40'b110);

    // Back-to-back: start held high, binary changed mid-conversion.
    @(negedge clk);
    ifa.start  = 1'b1;
    ifa.binary = 14'd123;
    @(posedge clk);
    #1;
    check("b2b_busy0", 40'(ifa.busy), 40'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    ifa.binary = 14'd999;
    lat = 4;
    while (ifa.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_lat1", 40'(lat), 40'd14);
    check("b2b_bcd1", 40'(ifa.bcd), 40'h0123);
    check("b2b_busy_done", 40'(ifa.busy), 40'd0);
    @(posedge clk);
    #1;
    check("b2b_restart_busy", 40'(ifa.busy), 40'd1);
    check("b2b_restart_done", 40'(ifa.done), 40'd0);
    ifa.start = 1'b0;
    lat = 0;
    while (ifa.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_lat2", 40'(lat), 40'd14);
    check("b2b_bcd2", 40'(ifa.bcd), 40'h0999);

    // Reset at step 5 aborts the conversion.
    @(negedge clk);
    ifa.start  = 1'b1;
    ifa.binary = 14'd3000;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy",  40'(ifa.busy),  40'd0);
    check("abort_done",  40'(ifa.done),  40'd0);
    check("abort_bcd",   40'(ifa.bcd),   40'd0);
    check("abort_blank", 40'(ifa.blank), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ifa.done === 1'b1) dones++;
    end
    check("abort_no_done", 40'(dones), 40'd0);
    conv_a(14'd59, lat);
    check("after_abort_lat", 40'(lat), 40'd14);
    res_a("v59", 16'h0059, 1'b0, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
